// File: rtl/wb_pkg.sv
// Shared constants for the writeback arbiter slice: default sizes, register
// address width and the fixed requester indices.
package wb_pkg;
  localparam int unsigned NREQ_DEFAULT = 3;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_REGS     = 32;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans requests starting at ptr and returns a one-hot
// grant for the first active request found (all-zero if none).
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = PW'((32'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin register-file write port plus busy-bit
// scoreboard. Define WB_BYPASS_EN to forward the write port onto the reads.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0]       req_data,
  input  logic                       issue_valid,
  input  logic [REG_ADDR_W-1:0]      issue_rd,
  output logic                       issue_stall,
  input  logic [REG_ADDR_W-1:0]      rs1,
  input  logic [REG_ADDR_W-1:0]      rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic                       rf_we,
  output logic [REG_ADDR_W-1:0]      rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  input  logic [XLEN-1:0]            rf_rdata1,
  input  logic [XLEN-1:0]            rf_rdata2,
  output logic [XLEN-1:0]            fwd_rdata1,
  output logic [XLEN-1:0]            fwd_rdata2
);
  localparam int unsigned PTR_W = ptr_width(NREQ);

  logic [PTR_W-1:0]      r_rr_ptr;
  logic [NUM_REGS-1:1]   r_busy;
  logic [NUM_REGS-1:0]   w_busy;
  logic [NREQ-1:0]       w_req;
  logic [NREQ-1:0]       w_grant;
  logic                  w_any;
  logic [PTR_W-1:0]      w_gidx;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [XLEN-1:0]       w_data;
  logic                  w_set_en;
  logic [NUM_REGS-1:1]   w_set;
  logic [NUM_REGS-1:1]   w_clr;

  // Requests are masked during reset so nothing is granted or written.
  assign w_req = reset ? '0 : req_valid;

  rr_arbiter #(.N(NREQ), .PW(PTR_W)) u_rr (
    .req  (w_req),
    .ptr  (r_rr_ptr),
    .grant(w_grant)
  );

  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_rd   = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_any  = 1'b1;
        w_gidx = PTR_W'(i);
        w_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        w_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign req_ready = w_grant;
  assign rf_we     = w_any && (w_rd != '0);
  assign rf_waddr  = w_rd;
  assign rf_wdata  = w_data;

  assign w_busy      = {r_busy, 1'b0};
  assign issue_stall = issue_valid && w_busy[issue_rd] && (issue_rd != '0);
  assign w_set_en    = issue_valid && !issue_stall && (issue_rd != '0);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      w_set[i] = w_set_en && (issue_rd == REG_ADDR_W'(i));
      w_clr[i] = rf_we && (rf_waddr == REG_ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_any)
        r_rr_ptr <= (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  logic w_hit1, w_hit2;
  assign w_hit1     = rf_we && (rf_waddr == rs1) && (rs1 != '0);
  assign w_hit2     = rf_we && (rf_waddr == rs2) && (rs2 != '0);
  assign fwd_rdata1 = w_hit1 ? rf_wdata : rf_rdata1;
  assign fwd_rdata2 = w_hit2 ? rf_wdata : rf_rdata2;
  assign rs1_busy   = w_busy[rs1] && !w_hit1;
  assign rs2_busy   = w_busy[rs2] && !w_hit2;
`else
  assign fwd_rdata1 = rf_rdata1;
  assign fwd_rdata2 = rf_rdata2;
  assign rs1_busy   = w_busy[rs1];
  assign rs2_busy   = w_busy[rs2];
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scenario tasks with a queue of expected
// write-port results popped when the DUT presents each grant.
module tb_wb_arbiter;
  import wb_pkg::*;
  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [NREQ-1:0] ready;
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*5-1:0] req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              issue_stall;
  logic [4:0]        rs1, rs2;
  logic              rs1_busy, rs2_busy;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic [XLEN-1:0]   fwd_rdata1, fwd_rdata2;

  wb_exp_t sb[$];
  wb_exp_t e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2)
  );

  task automatic clear_inputs();
    req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    req_valid[i] = 1'b1;
    req_rd[i*5 +: 5] = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic pop_compare(input string name);
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (req_ready !== e.ready || rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin
        errors++;
        $display("FAIL %s: got ready=%b we=%b addr=%0d data=%h, expected ready=%b we=%b addr=%0d data=%h",
                 name, req_ready, rf_we, rf_waddr, rf_wdata, e.ready, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    set_req(REQ_ALU, 5'd9, 32'h0000_0099);
    issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd9;
    next_cycle(); #4;
    checks++;
    if ({req_ready, rf_we, rf_waddr, rf_wdata} !== '0) begin
      errors++; $display("FAIL reset_wport: got ready=%b we=%b addr=%0d data=%h, expected all 0",
                         req_ready, rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if ({issue_stall, rs1_busy, rs2_busy} !== 3'b000) begin
      errors++; $display("FAIL reset_sb: got stall/rs1b/rs2b=%b, expected 000", {issue_stall, rs1_busy, rs2_busy});
    end
    next_cycle();
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_scoreboard();
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd5; #4;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL first_issue_stall: got %b expected 0", issue_stall); end
    next_cycle();
    issue_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd6; #4;
    checks++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL rs1_busy_after_issue: got %b expected 1", rs1_busy); end
    checks++;
    if (rs2_busy !== 1'b0) begin errors++; $display("FAIL rs2_busy_other: got %b expected 0", rs2_busy); end
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL reissue_stall: got %b expected 1", issue_stall); end
    issue_rd = 5'd0; #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL rd0_stall: got %b expected 0", issue_stall); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_bypass();
    next_cycle();
    set_req(REQ_LSU, 5'd5, 32'hDEAD_BEEF);
    rs2 = 5'd5; rf_rdata2 = 32'h0BAD_F00D;
    sb.push_back('{ready: 3'b010, we: 1'b1, addr: 5'd5, data: 32'hDEAD_BEEF});
    #4;
    pop_compare("lsu_write");
`ifdef WB_BYPASS_EN
    checks++;
    if (fwd_rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_data: got %h expected deadbeef", fwd_rdata2); end
    checks++;
    if (rs2_busy !== 1'b0) begin errors++; $display("FAIL bypass_busy: got %b expected 0", rs2_busy); end
`else
    checks++;
    if (fwd_rdata2 !== 32'h0BAD_F00D) begin errors++; $display("FAIL nobypass_data: got %h expected 0badf00d", fwd_rdata2); end
    checks++;
    if (rs2_busy !== 1'b1) begin errors++; $display("FAIL nobypass_busy: got %b expected 1", rs2_busy); end
`endif
    next_cycle();
    clear_inputs(); rs2 = 5'd5; #4;
    checks++;
    if (rs2_busy !== 1'b0) begin errors++; $display("FAIL busy_cleared: got %b expected 0", rs2_busy); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; next_cycle(); reset = 1'b0;
    next_cycle();
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);
    sb.push_back('{ready: 3'b001, we: 1'b1, addr: 5'd1, data: 32'hA000_0000});
    sb.push_back('{ready: 3'b010, we: 1'b1, addr: 5'd2, data: 32'hA000_0001});
    sb.push_back('{ready: 3'b100, we: 1'b1, addr: 5'd3, data: 32'hA000_0002});
    sb.push_back('{ready: 3'b001, we: 1'b1, addr: 5'd1, data: 32'hA000_0000});
    for (int c = 0; c < 4; c++) begin
      #4; pop_compare($sformatf("rr_cycle%0d", c));
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_no_grant();
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);
    req_valid = '0; #4;
    checks++;
    if ({req_ready, rf_we, rf_waddr, rf_wdata} !== '0) begin
      errors++; $display("FAIL idle_wport: got ready=%b we=%b addr=%0d data=%h, expected all 0",
                         req_ready, rf_we, rf_waddr, rf_wdata);
    end
    next_cycle(); next_cycle();
    req_valid = 3'b111;
    sb.push_back('{ready: 3'b010, we: 1'b1, addr: 5'd2, data: 32'hA000_0001});
    #4; pop_compare("ptr_hold");
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_rd_zero();
    issue_valid = 1'b1; issue_rd = 5'd4;
    next_cycle();
    issue_valid = 1'b0;
    set_req(REQ_ALU, 5'd0, 32'h0000_1234);
    rs1 = 5'd4; #4;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL rd0_ready: got %b expected 001", req_ready); end
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b expected 0", rf_we); end
    next_cycle();
    clear_inputs(); rs1 = 5'd4; #4;
    checks++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL rd0_busy_kept: got %b expected 1", rs1_busy); end
  endtask

  task automatic test_set_clear();
    issue_valid = 1'b1; issue_rd = 5'd5;
    next_cycle();
    issue_rd = 5'd7;
    set_req(REQ_MDU, 5'd5, 32'hCAFE_0005);
    sb.push_back('{ready: 3'b100, we: 1'b1, addr: 5'd5, data: 32'hCAFE_0005});
    #4; pop_compare("mdu_write");
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL setclr_stall: got %b expected 0", issue_stall); end
    next_cycle();
    clear_inputs(); rs1 = 5'd7; rs2 = 5'd5; #4;
    checks++;
    if ({rs1_busy, rs2_busy} !== 2'b10) begin
      errors++; $display("FAIL setclr_busy: got rs1b/rs2b=%b expected 10", {rs1_busy, rs2_busy});
    end
    issue_valid = 1'b1; issue_rd = 5'd7;
    set_req(REQ_ALU, 5'd7, 32'h7777_0007);
    sb.push_back('{ready: 3'b001, we: 1'b1, addr: 5'd7, data: 32'h7777_0007});
    #1; pop_compare("clear_vs_stall_write");
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL clear_keeps_stall: got %b expected 1", issue_stall); end
    next_cycle();
    clear_inputs(); rs1 = 5'd7; #4;
    checks++;
    if (rs1_busy !== 1'b0) begin errors++; $display("FAIL rd7_cleared: got %b expected 0", rs1_busy); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd9;
    next_cycle();
    issue_valid = 1'b0;
    set_req(REQ_ALU, 5'd9, 32'h9999_0009);
    rs1 = 5'd9; rs2 = 5'd4; #2;
    reset = 1'b1; #1;
    checks++;
    if ({req_ready, rf_we, rf_waddr, rf_wdata} !== '0) begin
      errors++; $display("FAIL midreset_wport: got ready=%b we=%b addr=%0d data=%h, expected all 0",
                         req_ready, rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if ({rs1_busy, rs2_busy} !== 2'b00) begin
      errors++; $display("FAIL midreset_busy: got rs1b/rs2b=%b expected 00", {rs1_busy, rs2_busy});
    end
    next_cycle();
    reset = 1'b0; clear_inputs();
    next_cycle();
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hB000_0000 + i);
    sb.push_back('{ready: 3'b001, we: 1'b1, addr: 5'd1, data: 32'hB000_0000});
    #4; pop_compare("ptr_after_reset");
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_scoreboard();
    test_bypass();
    test_round_robin();
    test_no_grant();
    test_rd_zero();
    test_set_clear();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left, expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of writeback requesters (0=ALU, 1=LSU, 2=MUL/DIV).
REQ-002 Parameter XLEN, default 32: register data width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  NREQ  per-requester writeback request.
REQ-006 req_ready  out  NREQ  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-007 req_rd  in  NREQ*5  destination register per requester; requester i occupies bits [5i+4:5i].
REQ-008 req_data  in  NREQ*XLEN  write data per requester; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
REQ-009 issue_valid  in  1  decode stage claims issue_rd for a pending write.
REQ-010 issue_rd  in  5  destination register being claimed.
REQ-011 issue_stall  out  1  claim refused; issue_rd is already busy.
REQ-012 rs1, rs2  in  5 each  source registers of the decoding instruction.
REQ-013 rs1_busy, rs2_busy  out  1 each  source has an outstanding write.
REQ-014 rf_we  out  1  register-file write enable.
REQ-015 rf_waddr  out  5  register-file write address.
REQ-016 rf_wdata  out  XLEN  register-file write data.
REQ-017 rf_rdata1, rf_rdata2  in  XLEN each  register-file read data for rs1/rs2.
REQ-018 fwd_rdata1, fwd_rdata2  out  XLEN each  read data after optional bypass.

Function
REQ-019 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high.
REQ-020 Arbitration SHALL be round-robin: search starts at rr_ptr; after a grant to i, rr_ptr SHALL become (i+1) mod NREQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-021 The write port SHALL be combinational from the grant: rf_we=1, rf_waddr=req_rd[g], rf_wdata=req_data[g] in the grant cycle; the register file commits it at the next edge.
REQ-022 A granted request with rd=0 SHALL be consumed (ready high) with rf_we=0 and no scoreboard change.
REQ-023 With no grant: rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-024 Scoreboard: 32 busy bits; bit 0 SHALL always read 0.
REQ-025 issue_stall SHALL equal issue_valid & busy[issue_rd] & (issue_rd!=0); a clear occurring in the same cycle SHALL NOT lift the stall.
REQ-026 busy[issue_rd] SHALL be set at the edge when issue_valid & !issue_stall & issue_rd!=0.
REQ-027 busy[rf_waddr] SHALL be cleared at the edge when rf_we=1.
REQ-028 A set and a clear of different registers in the same cycle SHALL both take effect.
REQ-029 rsN_busy SHALL equal busy[rsN] as currently registered.

Reset
REQ-030 While reset is high: all busy bits=0, rr_ptr=0, req_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, issue_stall=0, rs1_busy=rs2_busy=0.
REQ-031 Reset mid-transfer SHALL drop the transfer; no write SHALL reach the register file.

Configuration
REQ-032 Macro WB_BYPASS_EN defined: fwd_rdataN=rf_wdata when rf_we & rf_waddr==rsN & rsN!=0, else rf_rdataN; rsN_busy SHALL be 0 in that same cycle.
REQ-033 Macro WB_BYPASS_EN undefined: fwd_rdataN=rf_rdataN unconditionally; rsN_busy follows REQ-029 only.

Structure
REQ-034 Package wb_pkg SHALL hold NREQ_DEFAULT, XLEN_DEFAULT, REG_ADDR_W=5, and requester-index constants REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-036 Reset, then issue_rd=5 -> next cycle rs1=5 gives rs1_busy=1; re-issue of rd 5 -> issue_stall=1.
REQ-037 All three requesters valid continuously with rds 1, 2, 3 -> grants 0,1,2,0 on successive cycles; rf_waddr follows 1,2,3,1.
REQ-038 LSU writes rd 5 with data 0xDEADBEEF while rs2=5 -> bypass on: fwd_rdata2=0xDEADBEEF, rs2_busy=0; bypass off: fwd_rdata2=rf_rdata2, rs2_busy=1.
REQ-039 Requester with rd=0, data 0x1234 -> req_ready=1, rf_we=0, busy unchanged.
REQ-040 Issue rd 7 and grant write to rd 5 in the same cycle -> busy[7]=1, busy[5]=0 after the edge.
REQ-041 Reset asserted while ALU valid with rd 9 -> req_ready=0, rf_we=0, all busy=0, rr_ptr=0.
